// File: rtl/servisia_loader_pkg.sv
// Shared types and defaults for the servisia UART boot loader.
package servisia_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_e;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT    = 8'hA5;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;
    localparam int unsigned LEN_WIDTH            = 16;

endpackage

// File: rtl/servisia_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module servisia_uart_rx
    import servisia_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_ferr_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    rx_state_e        state;
    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Synchronize the line, detect the start edge and shift in bits at bit centres.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= RX_IDLE;
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;
        end else begin
            rx_meta    <= rx_i;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            rx_valid_o <= 1'b0;
            rx_ferr_o  <= 1'b0;

            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // A start bit that is high again at mid-bit was only a glitch.
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid_o <= 1'b1;
                            rx_data_o  <= shift;
                        end else begin
                            rx_ferr_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/servisia_uart_loader.sv
// Boot loader: parses a framed image from UART, writes it to SRAM from address 0,
// and releases the core reset only once the checksum matches.
module servisia_uart_loader
    import servisia_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_WIDTH   = 14,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  uart_rx_i,
    output logic [ADDR_WIDTH-1:0] sram_waddr_o,
    output logic [7:0]            sram_wdata_o,
    output logic                  sram_wen_o,
    output logic                  cpu_rst_no,
    output logic                  done_o,
    output logic                  error_o
);

    // Length is 16 bits on the wire; ADDR_WIDTH is expected to be at most 16.
    localparam int unsigned LEN_W1 = LEN_WIDTH + 1;
    localparam logic [LEN_W1-1:0] DEPTH = LEN_W1'(1 << ADDR_WIDTH);

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferr;

    loader_state_e        state;
    logic [7:0]           len_lo;
    logic [LEN_WIDTH-1:0] len;
    logic [LEN_WIDTH-1:0] cnt;
    logic [7:0]           sum;

    logic [LEN_WIDTH-1:0] len_full;
    logic [LEN_WIDTH-1:0] cnt_inc;

    assign len_full = {rx_data, len_lo};
    assign cnt_inc  = cnt + LEN_WIDTH'(1);

    servisia_uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rx_i       (uart_rx_i),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ferr_o  (rx_ferr)
    );

    // Frame FSM with length/address counter, running checksum and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            len_lo       <= '0;
            len          <= '0;
            cnt          <= '0;
            sum          <= '0;
            sram_waddr_o <= '0;
            sram_wdata_o <= '0;
            sram_wen_o   <= 1'b0;
            cpu_rst_no   <= 1'b0;
            done_o       <= 1'b0;
            error_o      <= 1'b0;
        end else begin
            sram_wen_o <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (rx_ferr) begin
                        state   <= ERROR;
                        error_o <= 1'b1;
                    end else if (rx_valid) begin
                        len_lo <= rx_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (rx_ferr) begin
                        state   <= ERROR;
                        error_o <= 1'b1;
                    end else if (rx_valid) begin
                        len <= len_full;
                        cnt <= '0;
                        sum <= '0;
                        if ({1'b0, len_full} > DEPTH) begin
                            state   <= ERROR;
                            error_o <= 1'b1;
                        end else if (len_full == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (rx_ferr) begin
                        state   <= ERROR;
                        error_o <= 1'b1;
                    end else if (rx_valid) begin
                        sram_wen_o   <= 1'b1;
                        sram_waddr_o <= cnt[ADDR_WIDTH-1:0];
                        sram_wdata_o <= rx_data;
                        sum          <= sum + rx_data;
                        cnt          <= cnt_inc;
                        if (cnt_inc == len) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (rx_ferr) begin
                        state   <= ERROR;
                        error_o <= 1'b1;
                    end else if (rx_valid) begin
                        if (rx_data == sum) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            cpu_rst_no <= 1'b1;
                        end else begin
                            state   <= ERROR;
                            error_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done_o     <= 1'b1;
                    cpu_rst_no <= 1'b1;
                end
                ERROR: begin
                    error_o    <= 1'b1;
                    cpu_rst_no <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servisia_uart_loader.sv
// Directed bench for the UART boot loader with a write scoreboard.
module tb_servisia_uart_loader;

    localparam int unsigned CLKS = 16;
    localparam int unsigned AW   = 14;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx;
    logic [AW-1:0] sram_waddr;
    logic [7:0]    sram_wdata;
    logic          sram_wen;
    logic          cpu_rst_n;
    logic          done;
    logic          error;

    int   total = 0;
    int   bad = 0;
    int   writes_seen = 0;
    logic wen_prev = 1'b0;
    wr_t  exp_q[$];
    logic [7:0] payload [4];

    servisia_uart_loader #(
        .CLKS_PER_BIT (CLKS),
        .ADDR_WIDTH   (AW),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .uart_rx_i    (rx),
        .sram_waddr_o (sram_waddr),
        .sram_wdata_o (sram_wdata),
        .sram_wen_o   (sram_wen),
        .cpu_rst_no   (cpu_rst_n),
        .done_o       (done),
        .error_o      (error)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write pulse must match the next expected {addr,data}.
    always @(negedge clk) begin
        wr_t got;
        wr_t want;
        if (sram_wen) begin
            writes_seen++;
            total++;
            assert (wen_prev === 1'b0) else begin
                bad++;
                $error("FAIL wen_width observed=multi-cycle expected=1 cycle");
            end
            total++;
            got = {sram_waddr, sram_wdata};
            if (exp_q.size() == 0) begin
                bad++;
                $error("FAIL unexpected_write observed=%0h/%0h expected=none", sram_waddr, sram_wdata);
            end else begin
                want = exp_q.pop_front();
                assert (got === want) else begin
                    bad++;
                    $error("FAIL write observed=%0h/%0h expected=%0h/%0h",
                           got.addr, got.data, want.addr, want.data);
                end
            end
        end
        wen_prev = sram_wen;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic c);
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_error"}, 32'(error), 32'(e));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(c));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_waddr"}, 32'(sram_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
        check({tag, "_wen"}, 32'(sram_wen), 32'd0);
        check_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        writes_seen = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
    endtask

    // Reference frame A5 04 00 DE AD BE EF <csum>; ferr_idx marks a payload byte sent with a bad stop bit.
    task automatic send_frame_a(input logic [7:0] csum, input int ferr_idx, input int n_push);
        for (int i = 0; i < n_push; i++) begin
            exp_q.push_back({AW'(i), payload[i]});
        end
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_byte(payload[i], (i != ferr_idx));
        end
        send_byte(csum, 1'b1);
    endtask

    initial begin
        payload[0] = 8'hDE;
        payload[1] = 8'hAD;
        payload[2] = 8'hBE;
        payload[3] = 8'hEF;
        rx    = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        writes_seen = 0;

        // Good load
        send_frame_a(8'h38, -1, 4);
        check("good_writes", 32'(writes_seen), 32'd4);
        check("good_q_empty", 32'(exp_q.size()), 32'd0);
        check_status("good", 1'b1, 1'b0, 1'b1);
        // Traffic after DONE is ignored
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        check("done_sticky_writes", 32'(writes_seen), 32'd4);
        check_status("done_sticky", 1'b1, 1'b0, 1'b1);

        // Bad checksum
        do_reset();
        send_frame_a(8'h39, -1, 4);
        check("badsum_writes", 32'(writes_seen), 32'd4);
        check_status("badsum", 1'b0, 1'b1, 1'b0);

        // Leading junk before sync
        do_reset();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        check("junk_writes", 32'(writes_seen), 32'd0);
        check_status("junk_idle", 1'b0, 1'b0, 1'b0);
        send_frame_a(8'h38, -1, 4);
        check("junk_load_writes", 32'(writes_seen), 32'd4);
        check_status("junk_load", 1'b1, 1'b0, 1'b1);

        // Oversize length 0x4001 > 16384
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h40, 1'b1);
        check("oversize_writes", 32'(writes_seen), 32'd0);
        check_status("oversize", 1'b0, 1'b1, 1'b0);

        // Zero-length image
        do_reset();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("zero_len_writes", 32'(writes_seen), 32'd0);
        check_status("zero_len", 1'b1, 1'b0, 1'b1);

        // Framing error on third payload byte
        do_reset();
        send_frame_a(8'h38, 2, 2);
        check("ferr_writes", 32'(writes_seen), 32'd2);
        check("ferr_q_empty", 32'(exp_q.size()), 32'd0);
        check_status("ferr", 1'b0, 1'b1, 1'b0);

        // Quarter-bit glitch in idle, then a normal load
        do_reset();
        rx = 1'b0;
        repeat (CLKS / 4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        check("glitch_writes", 32'(writes_seen), 32'd0);
        check_status("glitch", 1'b0, 1'b0, 1'b0);
        send_frame_a(8'h38, -1, 4);
        check("post_glitch_writes", 32'(writes_seen), 32'd4);
        check_status("post_glitch", 1'b1, 1'b0, 1'b1);

        // Reset mid-load with a byte partially on the line
        do_reset();
        exp_q.push_back({AW'(0), payload[0]});
        exp_q.push_back({AW'(1), payload[1]});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(payload[0], 1'b1);
        send_byte(payload[1], 1'b1);
        rx = 1'b0;
        repeat (CLKS + CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("midreset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset_writes", 32'(writes_seen), 32'd2);
        check("midreset_q_empty", 32'(exp_q.size()), 32'd0);
        writes_seen = 0;
        send_frame_a(8'h38, -1, 4);
        check("reload_writes", 32'(writes_seen), 32'd4);
        check("reload_q_empty", 32'(exp_q.size()), 32'd0);
        check_status("reload", 1'b1, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
